// File: rtl/adder_accumulator_pkg.sv
// Shared definitions for the adder_accumulator block: FSM state encoding and
// default datapath widths.
package adder_accumulator_pkg;

    localparam int unsigned DEFAULT_N  = 32;
    localparam int unsigned DEFAULT_CW = 16;
    localparam int unsigned SLICE_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Carry out of one 4-bit lookahead group, from its generate/propagate terms.
    function automatic logic group_carry(input logic [3:0] g, input logic [3:0] p,
                                         input logic c0);
        return g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
    endfunction

endpackage

// File: rtl/adder_accumulator_cla.sv
// N-bit carry-lookahead adder built from 4-bit lookahead slices; reports
// unsigned carry-out and signed overflow alongside the sum.
module adder_accumulator_cla
    import adder_accumulator_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         of
);

    localparam int unsigned SLICES = N / SLICE_W;

    logic [N-1:0]    gen;
    logic [N-1:0]    prop;
    logic [SLICES:0] blk_c;

    assign gen      = a & b;
    assign prop     = a ^ b;
    assign blk_c[0] = cin;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [3:0] sg;
        logic [3:0] sp;
        logic [3:0] c;

        assign sg = gen[SLICE_W*s +: SLICE_W];
        assign sp = prop[SLICE_W*s +: SLICE_W];

        assign c[0] = blk_c[s];
        assign c[1] = sg[0] | (sp[0] & c[0]);
        assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
        assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                    | (sp[2] & sp[1] & sp[0] & c[0]);

        assign blk_c[s+1] = group_carry(sg, sp, c[0]);
        assign sum[SLICE_W*s +: SLICE_W] = sp ^ c;
    end

    assign cout = blk_c[SLICES];
    // Overflow: both operands share a sign and the result's sign differs.
    assign of   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/adder_accumulator.sv
// Frame accumulator: sums accepted beats until in_last, then presents the sum,
// sticky carry/overflow flags and a saturating beat count until handshaked.
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_cout,
    output logic          out_of,
    output logic [CW-1:0] out_count
);

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   acc;
    logic [CW-1:0]  count;
    logic           cout_sticky;
    logic           of_sticky;

    logic [N-1:0]   add_sum;
    logic           add_cout;
    logic           add_of;
    logic [CW-1:0]  count_inc;
    logic           accept;
    logic           deliver;

    adder_accumulator_cla #(.N(N)) u_cla (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .of   (add_of)
    );

    // Saturating increment as a half-adder chain; an all-ones count is held.
    always_comb begin
        logic carry;
        count_inc = count;
        carry     = 1'b1;
        if (!(&count)) begin
            for (int unsigned i = 0; i < CW; i++) begin
                count_inc[i] = count[i] ^ carry;
                carry        = carry & count[i];
            end
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            cout_sticky <= 1'b0;
            of_sticky   <= 1'b0;
        end else begin
            state <= next_state;
            if (deliver) begin
                acc         <= '0;
                count       <= '0;
                cout_sticky <= 1'b0;
                of_sticky   <= 1'b0;
            end else if (accept) begin
                acc         <= add_sum;
                count       <= count_inc;
                cout_sticky <= cout_sticky | add_cout;
                of_sticky   <= of_sticky | add_of;
            end
        end
    end

    assign out_sum   = acc;
    assign out_cout  = cout_sticky;
    assign out_of    = of_sticky;
    assign out_count = count;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed and randomized frames against an arithmetic reference model; a
// second instance with CW=4 shares the stimulus to exercise count saturation.
module tb_adder_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_cout,  out_of;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        in_ready4, out_valid4, out_cout4, out_of4;
    logic [31:0] out_sum4;
    logic [3:0]  out_count4;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_sum;
    logic        m_cout, m_of;
    int          m_cnt;

    always #5 clk = ~clk;

    adder_accumulator #(.N(32), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_of(out_of), .out_count(out_count)
    );

    adder_accumulator #(.N(32), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
        .out_ready(out_ready), .out_sum(out_sum4), .out_cout(out_cout4),
        .out_of(out_of4), .out_count(out_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sum  = '0;
        m_cout = 1'b0;
        m_of   = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_sum"},    64'(out_sum),    64'(m_sum));
        chk({tag, "_cout"},   64'(out_cout),   64'(m_cout));
        chk({tag, "_of"},     64'(out_of),     64'(m_of));
        chk({tag, "_cnt"},    64'(out_count),  64'(sat(m_cnt, 65535)));
        chk({tag, "_sum4"},   64'(out_sum4),   64'(m_sum));
        chk({tag, "_cnt4"},   64'(out_count4), 64'(sat(m_cnt, 15)));
    endtask

    // Caller sits just after a falling edge; returns one cycle later.
    task automatic send_beat(input logic [31:0] d, input logic last);
        logic [63:0] wide;
        longint      s;
        chk("pre_beat_sum", 64'(out_sum), 64'(m_sum));
        chk("beat_ready", 64'({in_ready, in_ready4}), 64'(2'b11));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        wide   = {32'b0, m_sum} + {32'b0, d};
        s      = longint'($signed(m_sum)) + longint'($signed(d));
        m_cout = m_cout | wide[32];
        m_of   = m_of | (s > 64'sd2147483647) | (s < -64'sd2147483648);
        m_sum  = wide[31:0];
        m_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        chk("idle_hold_sum", 64'(out_sum), 64'(m_sum));
        chk("idle_hold_cnt", 64'(out_count), 64'(sat(m_cnt, 65535)));
    endtask

    task automatic finish_frame(input string tag, input int hold);
        chk({tag, "_valid"}, 64'({out_valid, out_valid4}), 64'(2'b11));
        chk({tag, "_nready"}, 64'({in_ready, in_ready4}), 64'(2'b00));
        check_regs(tag);
        repeat (hold) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_hold_nready"}, 64'(in_ready), 64'(0));
            check_regs({tag, "_hold"});
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_clear();
        chk({tag, "_after_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_after_ready"}, 64'(in_ready), 64'(1));
        check_regs({tag, "_after"});
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_valid", 64'(out_valid), 64'(0));
        check_regs("rst");

        send_beat(32'd5, 1'b0);
        send_beat(32'd7, 1'b0);
        send_beat(32'd9, 1'b1);
        chk("small_exp_sum", 64'(out_sum), 64'(21));
        finish_frame("small", 0);

        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h0000_0001, 1'b1);
        chk("sovf_exp_sum", 64'(out_sum), 64'h8000_0000);
        chk("sovf_exp_of", 64'(out_of), 64'(1));
        finish_frame("sovf", 0);

        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'h0000_0002, 1'b1);
        chk("ucarry_exp_cout", 64'(out_cout), 64'(1));
        chk("ucarry_exp_sum", 64'(out_sum), 64'(1));
        finish_frame("ucarry", 0);
        send_beat(32'd3, 1'b1);
        chk("cleared_exp_sum", 64'(out_sum), 64'(3));
        chk("cleared_exp_flags", 64'({out_cout, out_of}), 64'(0));
        finish_frame("cleared", 0);

        send_beat(32'hDEAD_BEEF, 1'b1);
        chk("single_exp_cnt", 64'(out_count), 64'(1));
        finish_frame("single", 10);

        send_beat(32'd100, 1'b0);
        send_beat(32'd200, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd300;
        in_last  = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_clear();
        chk("midrst_ready", 64'(in_ready), 64'(1));
        chk("midrst_valid", 64'(out_valid), 64'(0));
        check_regs("midrst");
        send_beat(32'd1, 1'b0);
        idle_cycles(3);
        send_beat(32'd2, 1'b1);
        chk("midrst_exp_sum", 64'(out_sum), 64'(3));
        finish_frame("postrst", 0);

        for (int i = 0; i < 17; i++) send_beat(32'd1, 1'(i == 16));
        chk("sat_exp_cnt4", 64'(out_count4), 64'(15));
        chk("sat_exp_cnt", 64'(out_count), 64'(17));
        finish_frame("sat", 0);

        send_beat(32'd4, 1'b1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        model_clear();
        chk("donerst_valid", 64'(out_valid), 64'(0));
        check_regs("donerst");

        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                send_beat(pick_data(), 1'(b == len - 1));
                if (b != len - 1 && $urandom_range(0, 3) == 0)
                    idle_cycles($urandom_range(1, 3));
            end
            finish_frame("rand", $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 Parameter N, default 32, operand/accumulator width; SHALL be a multiple of 4 and >= 8.
REQ-002 Parameter CW, default 16, beat-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_data  input  N  operand, two's complement or unsigned (both flags reported).
REQ-008 in_last  input  1  marks final beat of a frame; sampled only on an accepted beat.
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_sum  output  N  accumulated sum modulo 2^N.
REQ-012 out_cout  output  1  sticky unsigned carry-out over the frame.
REQ-013 out_of  output  1  sticky signed overflow over the frame.
REQ-014 out_count  output  CW  accepted beats in the frame, saturating.

Function
REQ-015 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-016 FSM states: IDLE, ACCUM, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; accepted beat with in_last=0 -> ACCUM; with in_last=1 -> DONE.
REQ-018 ACCUM: in_ready=1, out_valid=0; accepted beat with in_last=1 -> DONE; otherwise stay.
REQ-019 DONE: in_ready=0, out_valid=1; out_sum/flags/count held stable; handshake -> IDLE.
REQ-020 Each accepted beat: acc <= acc + in_data via the N-bit carry-lookahead adder, cin=0; registered, one-cycle latency.
REQ-021 Accumulator is zero on entry to IDLE; first beat therefore yields acc = in_data.
REQ-022 Per beat: cout_sticky |= adder cout; of_sticky |= adder overflow (operands same sign, sum sign differs).
REQ-023 Per beat: count increments by 1, saturates at 2^CW-1 (no wrap).
REQ-024 out_valid asserts the cycle after the in_last beat is accepted; no combinational path from in_* to out_*.
REQ-025 DONE->IDLE transition clears acc, count, sticky flags in the same edge; in_ready re-asserts next cycle.
REQ-026 out_valid held while out_ready=0 indefinitely; in_valid ignored in DONE (back-pressure).
REQ-027 Idle cycles (in_valid=0) in ACCUM leave all state unchanged.
REQ-028 out_sum, out_cout, out_of, out_count driven directly from state registers in all states.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, acc=0, count=0, flags=0; out_valid=0, in_ready=1 after that edge.
REQ-030 rst mid-frame or in DONE discards partial/pending result; no beat accepted on a rst cycle.
REQ-031 rst has priority over any concurrent handshake.

Structure
REQ-032 Shared package holds the state enum (IDLE/ACCUM/DONE encodings) and default N/CW constants.
REQ-033 Single sub-module: the team's N-bit carry-lookahead adder (4-bit CLA slices, sum/cout/of outputs), instanced once; no other arithmetic operators.

Verification
REQ-034 N=32: beats 5, 7, 9 (last on 9) -> out_valid one cycle later, out_sum=21, cout=0, of=0, count=3.
REQ-035 Beats 0x7FFFFFFF, 0x00000001 (last) -> out_sum=0x80000000, of=1, cout=0, count=2.
REQ-036 Beats 0xFFFFFFFF, 0x00000002 (last) -> out_sum=0x00000001, cout=1, of=0; then beat 3 (last) -> sum=3, flags cleared.
REQ-037 Single beat 0xDEADBEEF with in_last -> out_sum=0xDEADBEEF, count=1; hold out_ready=0 10 cycles -> outputs stable, in_ready=0.
REQ-038 rst after 2 of 4 beats, then frame 1, 2 (last) -> out_sum=3, count=2, no residue.
REQ-039 CW=4, 17 beats of 1 -> out_count=15 (saturated), out_sum=17.
